// File: rtl/clk_freq_monitor.sv
// clk_freq_monitor
//   Measures the period of a slow asynchronous input (e.g. a divided blink
//   clock looped back to a pin) in reference-clock cycles, checks it against
//   a tolerance window and flags loss of signal.
//
// Ports
//   clock         reference clock, all state on its rising edge
//   reset_n       asynchronous active-low reset
//   meas_in       asynchronous signal being measured
//   period        last measured period in clock cycles
//   period_valid  one-cycle pulse when period updates
//   in_range      last period within [MIN_PERIOD, MAX_PERIOD]
//   lost          high while no rising edge has been seen for TIMEOUT cycles
//   good_count    saturating count of in-range periods
//   err_count     saturating count of out-of-range periods
module clk_freq_monitor #(
  parameter int WIDTH      = 32,
  parameter int MIN_PERIOD = 247500000,
  parameter int MAX_PERIOD = 252500000,
  parameter int TIMEOUT    = 500000000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             meas_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             in_range,
  output logic             lost,
  output logic [15:0]      good_count,
  output logic [15:0]      err_count
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, LOST} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] MIN_W     = WIDTH'(MIN_PERIOD);
  localparam logic [WIDTH-1:0] MAX_W     = WIDTH'(MAX_PERIOD);

  state_t           state, state_nx;
  logic             s1, s2, s3;
  logic             edge_hit, timeout_hit, report, cnt_ok;
  logic [WIDTH-1:0] cnt;

  assign edge_hit    = s2 & ~s3;
  // A coincident edge beats the timeout so a period of exactly TIMEOUT
  // is still reported rather than declared lost.
  assign timeout_hit = ~edge_hit && (cnt == TIMEOUT_W);
  assign report      = (state == MEASURE) && edge_hit;
  assign cnt_ok      = (cnt >= MIN_W) && (cnt <= MAX_W);

  // Synchroniser plus history flop for rising-edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= meas_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Free-running cycle counter, restarted at 1 on each edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)          cnt <= '0;
    else if (edge_hit)     cnt <= {{(WIDTH-1){1'b0}}, 1'b1};
    else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // IDLE waits for a low synchronised input so a high level at reset
  // release is not mistaken for a fresh rising edge by the ARM stage.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (timeout_hit) state_nx = LOST;
               else if (!s2)    state_nx = ARM;
      ARM:     if (edge_hit)    state_nx = MEASURE;
               else if (timeout_hit) state_nx = LOST;
      MEASURE: if (timeout_hit) state_nx = LOST;
      LOST:    if (edge_hit)    state_nx = MEASURE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      period       <= '0;
      period_valid <= 1'b0;
      in_range     <= 1'b0;
      lost         <= 1'b0;
      good_count   <= '0;
      err_count    <= '0;
    end else begin
      period_valid <= report;
      lost         <= (state_nx == LOST);
      if (report) begin
        period   <= cnt;
        in_range <= cnt_ok;
        if (cnt_ok) begin
          if (good_count != 16'hFFFF) good_count <= good_count + 16'd1;
        end else begin
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
      end else if (state != LOST && state_nx == LOST) begin
        in_range <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_freq_monitor.sv
// tb_clk_freq_monitor
//   Directed and randomised stimulus for clk_freq_monitor with a small
//   reference model: samples are queued per clock, rising edges are seen two
//   samples late, and periods are the cycle distance between edges.
module tb_clk_freq_monitor;

  localparam int W   = 8;
  localparam int MIN = 8;
  localparam int MAX = 12;
  localparam int TO  = 20;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         meas_in = 1'b0;
  logic [W-1:0] period;
  logic         period_valid, in_range, lost;
  logic [15:0]  good_count, err_count;

  int n_cmp = 0;
  int n_fail = 0;

  clk_freq_monitor #(.WIDTH(W), .MIN_PERIOD(MIN), .MAX_PERIOD(MAX), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n), .meas_in(meas_in),
    .period(period), .period_valid(period_valid), .in_range(in_range),
    .lost(lost), .good_count(good_count), .err_count(err_count)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  bit        hist[$];          // most recent sample first
  int        m_since;          // cycles since last detected edge (capped)
  int        m_phase;          // 0 wait-low, 1 armed, 2 measuring, 3 lost
  int        m_period;
  bit        m_valid, m_inr, m_lost;
  int        good_inc, err_inc;
  int        good_base = 0;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    bit s2v, s3v, e, tmo;
    if (!reset_n) begin
      hist.delete();
      m_since <= 0; m_phase <= 0; m_period <= 0;
      m_valid <= 0; m_inr <= 0; m_lost <= 0;
      good_inc <= 0; err_inc <= 0;
    end else begin
      s2v = (hist.size() > 1) ? hist[1] : 1'b0;
      s3v = (hist.size() > 2) ? hist[2] : 1'b0;
      e   = s2v && !s3v;
      tmo = !e && (m_since == TO);
      m_valid <= 0;
      case (m_phase)
        0: if (tmo) begin m_phase <= 3; m_lost <= 1; m_inr <= 0; end
           else if (!s2v) m_phase <= 1;
        1: if (e) m_phase <= 2;
           else if (tmo) begin m_phase <= 3; m_lost <= 1; m_inr <= 0; end
        2: if (e) begin
             m_period <= m_since;
             m_valid  <= 1;
             if (m_since >= MIN && m_since <= MAX) begin
               m_inr <= 1; good_inc <= good_inc + 1;
             end else begin
               m_inr <= 0; err_inc <= err_inc + 1;
             end
           end else if (tmo) begin m_phase <= 3; m_lost <= 1; m_inr <= 0; end
        default: if (e) begin m_phase <= 2; m_lost <= 0; end
      endcase
      m_since <= e ? 1 : ((m_since >= 255) ? 255 : m_since + 1);
      hist.push_front(meas_in);
      if (hist.size() > 3) void'(hist.pop_back());
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("period",       int'(period),       m_period);
    check("period_valid", int'(period_valid), int'(m_valid));
    check("in_range",     int'(in_range),     int'(m_inr));
    check("lost",         int'(lost),         int'(m_lost));
    check("good_count",   int'(good_count),   sat16(good_base + good_inc));
    check("err_count",    int'(err_count),    sat16(err_inc));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, int'(period), 0);
    check({tag, "_valid"},  int'(period_valid), 0);
    check({tag, "_range"},  int'(in_range), 0);
    check({tag, "_lost"},   int'(lost), 0);
    check({tag, "_good"},   int'(good_count), 0);
    check({tag, "_err"},    int'(err_count), 0);
  endtask

  task automatic step(input bit v);
    @(negedge clock);
    check_all();
    meas_in = v;
  endtask

  task automatic square(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < per; j++) step(j < hi);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int per, hi;
    // reset state
    repeat (3) @(negedge clock);
    check_zero("reset");
    reset_n = 1'b1;

    // nominal 10-cycle period
    square(10, 5, 6);
    check("nom_period", int'(period), 10);
    check("nom_range",  int'(in_range), 1);
    check("nom_err",    int'(err_count), 0);
    check("nom_good",   int'(good_count), 5);

    // too-fast 6-cycle period
    square(6, 3, 6);
    check("fast_period", int'(period), 6);
    check("fast_range",  int'(in_range), 0);

    // back to 10, then stop toggling -> lost, period held
    square(10, 5, 3);
    repeat (30) step(1'b0);
    check("lost_flag",   int'(lost), 1);
    check("lost_range",  int'(in_range), 0);
    check("lost_period", int'(period), 10);

    // resume: first edge only restarts timing
    square(10, 5, 4);
    check("resume_lost",  int'(lost), 0);
    check("resume_range", int'(in_range), 1);

    // period exactly TIMEOUT: edge wins over timeout
    square(20, 10, 4);
    check("to_period", int'(period), 20);
    check("to_lost",   int'(lost), 0);
    check("to_range",  int'(in_range), 0);

    // input held high through reset release
    @(negedge clock);
    reset_n = 1'b0; meas_in = 1'b1; good_base = 0;
    repeat (3) @(negedge clock);
    check_zero("hirst");
    reset_n = 1'b1;
    repeat (4) step(1'b1);
    repeat (5) step(1'b0);
    square(10, 5, 4);
    check("hi_period", int'(period), 10);
    check("hi_range",  int'(in_range), 1);

    // reset pulse between clock edges mid-measurement
    square(10, 5, 1);
    repeat (3) step(1'b1);
    @(posedge clock);
    #2 reset_n = 1'b0; good_base = 0;
    #1 check_zero("async");
    @(negedge clock);
    check_zero("async_hold");
    reset_n = 1'b1; meas_in = 1'b0;
    square(10, 5, 4);

    // good_count saturation: preload near the top, then run good periods
    @(negedge clock);
    dut.good_count = 16'hFFFD;
    good_base = 65533 - good_inc;
    square(10, 5, 6);
    check("sat_good", int'(good_count), 16'hFFFF);

    // randomised periods, duty and occasional dropouts
    for (int r = 0; r < 60; r++) begin
      per = $urandom_range(24, 4);
      hi  = $urandom_range(per - 1, 1);
      square(per, hi, $urandom_range(3, 1));
      if ($urandom_range(4, 0) == 0) repeat ($urandom_range(30, 15)) step(1'b0);
    end
    step(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
